// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, through a
// full-subtractor cell with a registered borrow; single-cycle done pulse on completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_amsb;
  logic             r_bmsb;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSB pair and the running borrow
  assign w_ai       = r_a[0];
  assign w_bi       = r_b[0];
  assign w_d        = w_ai ^ w_bi ^ r_br;
  assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last     = (r_cnt == LAST);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          if (w_last) begin
            // The final cell's d is the result MSB, so overflow is judged on it directly
            diff    <= w_res_next;
            bout    <= w_br_next;
            ovf     <= (r_amsb != r_bmsb) & (w_d != r_amsb);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table plus hand-written multi-cycle
// sequences on an 8-bit instance, with 2- and 16-bit instances against a reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st8 = 1'b0, st2 = 1'b0, st16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy8, done8, bout8, ovf8;
  logic        busy2, done2, bout2, ovf2;
  logic        busy16, done16, bout16, ovf16;
  logic [7:0]  diff8;
  logic [1:0]  diff2;
  logic [15:0] diff16;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );
  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
  );
  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
  );

  int checks   = 0;
  int failures = 0;
  int cur_w    = 8;

  logic        m_busy, m_done, m_bout, m_ovf;
  logic [15:0] m_diff;

  always_comb begin
    m_busy = busy8;
    m_done = done8;
    m_diff = {8'h00, diff8};
    m_bout = bout8;
    m_ovf  = ovf8;
    if (cur_w == 2) begin
      m_busy = busy2;
      m_done = done2;
      m_diff = {14'h0, diff2};
      m_bout = bout2;
      m_ovf  = ovf2;
    end else if (cur_w == 16) begin
      m_busy = busy16;
      m_done = done16;
      m_diff = diff16;
      m_bout = bout16;
      m_ovf  = ovf16;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [15:0] ai, input logic [15:0] bi);
    cur_w = w;
    case (w)
      2:       begin st2 = s;  a2 = ai[1:0];  b2 = bi[1:0];  end
      16:      begin st16 = s; a16 = ai;      b16 = bi;      end
      default: begin st8 = s;  a8 = ai[7:0];  b8 = bi[7:0];  end
    endcase
  endtask

  task automatic issue(input int w, input logic [15:0] ai, input logic [15:0] bi);
    @(negedge clk);
    drive(w, 1'b1, ai, bi);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  // Counts negedges after the accepting edge until done; cyc0/busy0 carry cycles already observed
  task automatic wait_done(input int cyc0, input int busy0, input logic [15:0] ed,
                           input logic eb, input logic eo, input string tag);
    int cyc = cyc0;
    int bc  = busy0;
    bit got = 1'b0;
    bit both = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m_busy && m_done) both = 1'b1;
      if (m_busy) bc++;
      if (m_done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(cur_w + 1));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(cur_w));
    chk({tag, "_busy_and_done"}, 32'(both), 32'd0);
    chk({tag, "_diff"}, 32'(m_diff), 32'(ed));
    chk({tag, "_bout"}, 32'(m_bout), 32'(eb));
    chk({tag, "_ovf"}, 32'(m_ovf), 32'(eo));
  endtask

  task automatic watch_no_done(input int n, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_done || m_busy) seen = 1'b1;
    end
    chk({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  function automatic void model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                                output logic [15:0] d, output logic bo, output logic ov);
    logic [15:0] mask;
    logic [15:0] am, bm;
    mask = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
    am   = ai & mask;
    bm   = bi & mask;
    d    = (am - bm) & mask;
    bo   = (am < bm);
    ov   = (am[w-1] != bm[w-1]) && (d[w-1] != am[w-1]);
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [15:0] ra, rb, ed;
    logic        eb, eo;
    int          bc;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
    vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_diff", 32'(diff8), 32'd0);
    chk("reset_bout", 32'(bout8), 32'd0);
    chk("reset_ovf", 32'(ovf8), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      begin
        issue(8, 16'(vecs[i].a), 16'(vecs[i].b));
        wait_done(0, 0, 16'(vecs[i].diff), vecs[i].bout, vecs[i].ovf, $sformatf("vec%0d", i));
      end

    // Second start during SHIFT is ignored; then a start in the DONE cycle runs back-to-back
    issue(8, 16'h05, 16'h03);
    bc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_busy) bc++;
    end
    drive(8, 1'b1, 16'hFF, 16'h00);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 16'h00, 16'h00);
    wait_done(3, bc, 16'h02, 1'b0, 1'b0, "ignore_mid");
    drive(8, 1'b1, 16'h10, 16'h01);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 16'h00, 16'h00);
    wait_done(0, 0, 16'h0F, 1'b0, 1'b0, "back2back");

    // Reset in the middle of an operation discards it and clears held results
    issue(8, 16'h05, 16'h03);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_diff", 32'(diff8), 32'd0);
    chk("midrst_bout", 32'(bout8), 32'd0);
    chk("midrst_ovf", 32'(ovf8), 32'd0);
    watch_no_done(12, "midrst");
    issue(8, 16'h09, 16'h04);
    wait_done(0, 0, 16'h05, 1'b0, 1'b0, "after_rst");

    // Reset and start together: reset wins
    @(negedge clk);
    rst = 1'b1;
    drive(8, 1'b1, 16'h05, 16'h03);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(8, 1'b0, 16'h00, 16'h00);
    watch_no_done(12, "rst_and_start");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      model(8, ra, rb, ed, eb, eo);
      issue(8, ra, rb);
      wait_done(0, 0, ed, eb, eo, $sformatf("rnd8_%0h_%0h", ra[7:0], rb[7:0]));
    end

    for (int i = 0; i < 16; i++) begin
      ra = 16'(i / 4);
      rb = 16'(i % 4);
      model(2, ra, rb, ed, eb, eo);
      issue(2, ra, rb);
      wait_done(0, 0, ed, eb, eo, $sformatf("w2_%0d_%0d", ra, rb));
    end

    issue(16, 16'h0000, 16'hFFFF);
    wait_done(0, 0, 16'h0001, 1'b1, 1'b0, "w16_0_ffff");
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      model(16, ra, rb, ed, eb, eo);
      issue(16, ra, rb);
      wait_done(0, 0, ed, eb, eo, $sformatf("rnd16_%0h_%0h", ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes `a - b` one bit per clock, LSB first, using a full-subtractor cell and a registered borrow. It is the inverse arithmetic counterpart of the team's combinational full-adder cell and serves area-constrained datapaths that can trade latency for logic. Operands are captured on a start request, and a single-cycle `done` pulse marks valid results.

## Interface
- `WIDTH`, default 8, operand and result width in bits (≥ 2).

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; operands sampled when accepted.
- `a` in WIDTH: minuend, unsigned or two's complement.
- `b` in WIDTH: subtrahend.
- `busy` out 1: high while a subtraction is in progress.
- `done` out 1: one-cycle pulse, results valid.
- `diff` out WIDTH: `a - b` modulo 2^WIDTH.
- `bout` out 1: final borrow; 1 when unsigned `a < b`.
- `ovf` out 1: signed overflow of two's-complement `a - b`.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - SHIFT: processing, WIDTH cycles.
  - DONE: one cycle, results presented.
- IDLE: `start`=1 latches `a`, `b` into internal shift registers, clears borrow and the bit counter, and records `a[MSB]` and `b[MSB]`. Moves to SHIFT.
- SHIFT, each cycle, with ai/bi = LSBs of the shift registers and br = borrow register:
  - d = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - d is shifted into the MSB of the internal result register, which shifts right.
  - The operand registers shift right and the counter increments.
- When the counter reaches WIDTH-1 (last bit), the FSM moves to DONE. On that same edge:
  - `diff` gets the full result.
  - `bout` gets br_next.
  - `ovf` gets (aMSB != bMSB) & (d != aMSB).
- DONE: `done`=1 for exactly one cycle. `diff`, `bout` and `ovf` are held until the next completion, not cleared.
- Start acceptance:
  - `start` is accepted in IDLE and in DONE. Acceptance in DONE allows back-to-back operation, with the FSM going to SHIFT and new operands captured.
  - `start` is ignored in SHIFT. Operand inputs are don't-care outside the accepting cycle.
- Output `diff`/`bout`/`ovf` registers update only on completion. Intermediate shift state is never visible.
- Reset mid-operation: the FSM returns to IDLE, all outputs and internal registers clear, the partial result is discarded and no `done` is issued.
- `rst` and `start` high together: reset wins and the request is dropped.
- Counter width is clog2(WIDTH). It must not wrap inside an operation.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0, FSM in IDLE.
- `start` sampled at edge E0 means:
  - `busy`=1 from after E0 through the cycle ending at E(WIDTH).
  - Bits 0..WIDTH-1 are processed at edges E1..E(WIDTH).
  - `done`=1 and results are valid in the cycle after E(WIDTH).
- Latency is WIDTH+1 cycles from start acceptance to `done`. Throughput is one operation per WIDTH+1 cycles with back-to-back start.
- `busy` and `done` are never high simultaneously.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, `a`=0x05, `b`=0x03, start pulse -> after 9 cycles `done`=1 with `diff`=0x02, `bout`=0, `ovf`=0. `busy` is high for exactly 8 cycles.
- `a`=0x03, `b`=0x05 -> `diff`=0xFE, `bout`=1, `ovf`=0. `a`=0x00, `b`=0x00 -> `diff`=0x00, `bout`=0, `ovf`=0.
- `a`=0x80, `b`=0x01 -> `diff`=0x7F, `bout`=0, `ovf`=1. `a`=0x7F, `b`=0xFF -> `diff`=0x80, `bout`=1, `ovf`=1.
- Start with 0x05/0x03, then pulse `start` with 0xFF/0x00 at cycle 3 -> second request ignored; result 0x02. Then `start` in the DONE cycle with 0x10/0x01 -> `done` 9 cycles later with `diff`=0x0F.
- Start with 0x05/0x03, assert `rst` at cycle 4 -> no `done`; `busy`, `diff`, `bout`, `ovf` all 0 after the reset edge. A subsequent start with 0x09/0x04 gives `diff`=0x05.
- Random regression: 1000 random WIDTH=8 operand pairs compared against a reference model of `a - b`, borrow and signed overflow. Repeat with WIDTH=2 and WIDTH=16 for 0x0000-0xFFFF → `diff`=0x0001, `bout`=1.
